// File: rtl/boron_pkg.sv
// ---------------------------------------------------------------------------
// boron_pkg
// Shared constants and types for the BORON cipher core and its arbiter.
//   BLOCK_W / KEY_W / ROUNDS : core geometry (64-bit block, 80-bit key, 25 rounds)
//   MODE_ENC / MODE_DEC      : mode encoding on req_mode / core_mode
//   arb_state_e              : 2-bit arbiter FSM state
// ---------------------------------------------------------------------------
package boron_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int ROUNDS  = 25;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_e;

endpackage

// File: rtl/boron_rr_arbiter.sv
// ---------------------------------------------------------------------------
// boron_rr_arbiter
// Two-way round-robin grant logic (purely combinational).
//   req       in  2  request vector
//   ptr       in  1  preferred requester when both request
//   grant     out 2  one-hot grant (all zero when nobody requests)
//   grant_idx out 1  index of the granted requester
// ---------------------------------------------------------------------------
module boron_rr_arbiter (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_idx = 1'b0;
    grant     = 2'b00;
    if (req == 2'b11) begin
      grant_idx = ptr;
    end else begin
      // Single requester wins regardless of the pointer.
      grant_idx = req[1];
    end
    if (req != 2'b00) begin
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/boron_core_arbiter.sv
// ---------------------------------------------------------------------------
// boron_core_arbiter
// Shares one BORON enc/dec core between two requesters. Grants one request at
// a time in round-robin order, pulses core_start, waits for core_done and
// returns the result through a per-requester response handshake.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   req_valid/req_ready [1:0]  request handshake, bit i = requester i
//   req_mode [1:0]             0 = encrypt, 1 = decrypt
//   req_text [127:0]           {text1, text0}
//   req_key  [159:0]           {key1, key0}
//   core_start/mode/text/key   start pulse and latched operands to the core
//   core_done, core_result     completion pulse and result from the core
//   rsp_valid/rsp_ready [1:0]  response handshake, bit i = requester i
//   rsp_data, rsp_err          shared result, timeout-abort flag
//
// Build option: define BORON_ARB_TIMEOUT_EN to abort BUSY after
// TIMEOUT_CYCLES cycles without core_done (response with rsp_err=1, data 0).
// ---------------------------------------------------------------------------
module boron_core_arbiter
  import boron_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_mode,
  input  logic [2*BLOCK_W-1:0] req_text,
  input  logic [2*KEY_W-1:0]   req_key,
  output logic                 core_start,
  output logic                 core_mode,
  output logic [BLOCK_W-1:0]   core_text,
  output logic [KEY_W-1:0]     core_key,
  input  logic                 core_done,
  input  logic [BLOCK_W-1:0]   core_result,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [BLOCK_W-1:0]   rsp_data,
  output logic                 rsp_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("boron_core_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e state, state_nxt;
  logic       ptr;        // round-robin pointer
  logic       gnt_idx;    // requester owning the current operation
  logic [1:0] arb_grant;
  logic       arb_idx;
  logic       timeout_hit;

  boron_rr_arbiter u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // Next state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    req_ready  = 2'b00;
    core_start = 1'b0;
    rsp_valid  = 2'b00;
    case (state)
      ST_IDLE: begin
        // Reset holds the FSM in IDLE; keep ready low so nothing looks accepted.
        if (!reset) req_ready = arb_grant;
        if (req_valid != 2'b00) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        core_start = 1'b1;
        state_nxt  = ST_BUSY;
      end
      ST_BUSY: begin
        if (core_done || timeout_hit) state_nxt = ST_RESPOND;
      end
      ST_RESPOND: begin
        rsp_valid[gnt_idx] = 1'b1;
        if (rsp_ready[gnt_idx]) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand latch, result capture and pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= 1'b0;
      gnt_idx   <= 1'b0;
      core_mode <= MODE_ENC;
      core_text <= '0;
      core_key  <= '0;
      rsp_data  <= '0;
    end else begin
      // Operands change only on a grant, so they stay put for the core.
      if (state == ST_IDLE && req_valid != 2'b00) begin
        gnt_idx   <= arb_idx;
        core_mode <= req_mode[arb_idx];
        core_text <= arb_idx ? req_text[2*BLOCK_W-1:BLOCK_W] : req_text[BLOCK_W-1:0];
        core_key  <= arb_idx ? req_key[2*KEY_W-1:KEY_W]      : req_key[KEY_W-1:0];
      end
      // core_done takes priority over a coincident timeout.
      if (state == ST_BUSY) begin
        if (core_done)        rsp_data <= core_result;
        else if (timeout_hit) rsp_data <= '0;
      end
      if (state == ST_RESPOND && rsp_ready[gnt_idx]) ptr <= ~gnt_idx;
    end
  end

`ifdef BORON_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] busy_cnt;

  // Cleared in ISSUE so it reads 0 on the first BUSY cycle; expiry on the
  // TIMEOUT_CYCLES-th BUSY cycle puts RESPOND exactly TIMEOUT_CYCLES after entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  busy_cnt <= '0;
    else if (state == ST_ISSUE) busy_cnt <= '0;
    else if (state == ST_BUSY)  busy_cnt <= busy_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_BUSY) && (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_err <= 1'b0;
    end else if (state == ST_BUSY) begin
      if (core_done)        rsp_err <= 1'b0;
      else if (timeout_hit) rsp_err <= 1'b1;
    end
  end
`else
  // No abort path: BUSY waits for core_done indefinitely.
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_boron_core_arbiter.sv
`timescale 1ns/1ps
module tb_boron_core_arbiter;

  localparam int L       = 27;  // stub core latency
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
  logic [127:0] req_text;
  logic [159:0] req_key;
  logic         core_start, core_mode, core_done, rsp_err;
  logic [63:0]  core_text, core_result, rsp_data;
  logic [79:0]  core_key;

  always #5 clk = ~clk;

  boron_core_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mode    (req_mode),
    .req_text    (req_text),
    .req_key     (req_key),
    .core_start  (core_start),
    .core_mode   (core_mode),
    .core_text   (core_text),
    .core_key    (core_key),
    .core_done   (core_done),
    .core_result (core_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
  );

  // ---------------- stub core: fixed latency L ----------------
  int          stub_cnt;
  logic        stub_busy;
  logic [63:0] stub_res;
  logic        suppress_done = 1'b0;
  logic        inject_done   = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
      stub_res  <= '0;
    end else if (core_start) begin
      stub_busy <= 1'b1;
      stub_cnt  <= L - 1;
      stub_res  <= core_mode ? (core_text ^ ~core_key[63:0]) : (core_text ^ core_key[63:0]);
    end else if (stub_busy) begin
      if (stub_cnt == 0) stub_busy <= 1'b0;
      else               stub_cnt  <= stub_cnt - 1;
    end
  end

  assign core_done   = (stub_busy && stub_cnt == 0 && !suppress_done) || inject_done;
  assign core_result = inject_done ? 64'hBAD0_BAD0_BAD0_BAD0 : stub_res;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic model_ptr = 1'b0;

  function automatic logic [63:0] model_result(input logic m, input logic [63:0] t, input logic [79:0] k);
    logic [63:0] kl;
    kl = k[63:0];
    return m ? (t ^ ~kl) : (t ^ kl);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic m, input logic [63:0] t, input logic [79:0] k);
    req_mode[i] = m;
    if (i == 1) begin
      req_text[127:64] = t;
      req_key[159:80]  = k;
    end else begin
      req_text[63:0] = t;
      req_key[79:0]  = k;
    end
    req_valid[i] = 1'b1;
  endtask

  // Serve one request; DUT must be in IDLE with requests already driven.
  task automatic serve(input int bp, input bit stray, input bit expect_timeout);
    logic        g;
    logic [1:0]  oh;
    logic        m;
    logic [63:0] t, exp_data;
    logic [79:0] k;
    int          lat, exp_lat;
    bit          wait_bad, bp_bad;
    #1;
    if (req_valid == 2'b11) g = model_ptr;
    else                    g = (req_valid == 2'b10);
    oh = g ? 2'b10 : 2'b01;
    m  = req_mode[g];
    t  = g ? req_text[127:64] : req_text[63:0];
    k  = g ? req_key[159:80]  : req_key[79:0];
    check("req_ready_grant", req_ready, oh);
    step();                                   // T+1
    check("core_start", core_start, 1'b1);
    check("core_mode", core_mode, m);
    check("core_text", core_text, t);
    check("core_key", core_key, k);
    check("req_ready_issue", req_ready, 2'b00);
    req_valid[g] = 1'b0;
    lat = 1;
    wait_bad = 0;
    while (rsp_valid == 2'b00 && lat < 300) begin
      step();
      lat++;
      if (req_ready != 2'b00 || core_start) wait_bad = 1;
    end
    exp_lat  = expect_timeout ? (2 + TIMEOUT) : (2 + L);
    exp_data = expect_timeout ? 64'h0 : model_result(m, t, k);
    check("rsp_latency", lat, exp_lat);
    check("busy_quiet", wait_bad, 1'b0);
    check("rsp_valid", rsp_valid, oh);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_err", rsp_err, expect_timeout);
    rsp_ready = stray ? ~oh : 2'b00;
    bp_bad = 0;
    for (int i = 0; i < bp; i++) begin
      step();
      if (rsp_valid !== oh || rsp_data !== exp_data || req_ready !== 2'b00) bp_bad = 1;
    end
    if (bp > 0) check("backpressure_hold", bp_bad, 1'b0);
    rsp_ready = stray ? 2'b11 : oh;
    step();                                   // R+1
    rsp_ready = 2'b00;
    model_ptr = ~g;
    #1;
    check("rsp_valid_cleared", rsp_valid, 2'b00);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit bad;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_mode  = 2'b00;
    req_text  = '0;
    req_key   = '0;
    rsp_ready = 2'b00;
    step();
    step();
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_core_start", core_start, 1'b0);
    check("reset_rsp_valid", rsp_valid, 2'b00);
    check("reset_rsp_data", rsp_data, 64'h0);
    reset = 1'b0;
    step();

    // Single request with known answer
    set_req(0, 1'b0, 64'h0123456789ABCDEF, 80'h0);
    serve(0, 0, 0);

    // Reset mid-BUSY (rsp_data is nonzero going in)
    set_req(0, 1'b1, 64'h1111_2222_3333_4444, 80'hA5A5_0F0F_1234_5678_9ABC);
    step();
    step();
    repeat (5) step();
    req_valid = 2'b00;
    reset = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_mode", core_mode, 1'b0);
    check("rst_core_text", core_text, 64'h0);
    check("rst_core_key", core_key, 80'h0);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_data", rsp_data, 64'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    step();
    reset = 1'b0;
    model_ptr = 1'b0;
    bad = 0;
    repeat (40) begin
      step();
      if (rsp_valid != 2'b00 || core_start) bad = 1;
    end
    check("rst_no_response", bad, 1'b0);

    // Contention from reset pointer, then again; first with backpressure and stray ready
    set_req(0, 1'b0, 64'hDEAD_BEEF_0000_0001, 80'h1_2345_6789_ABCD_EF01);
    set_req(1, 1'b1, 64'hCAFE_F00D_0000_0002, 80'hF_EDCB_A987_6543_2100);
    serve(10, 1, 0);
    serve(0, 0, 0);
    set_req(0, 1'b1, 64'h0F0F_0F0F_F0F0_F0F0, 80'h0_0000_FFFF_0000_FFFF);
    set_req(1, 1'b0, 64'h1234_5678_9ABC_DEF0, 80'h8_0000_0000_0000_0001);
    serve(0, 0, 0);
    serve(3, 1, 0);

    // Decrypt from requester 1 alone
    set_req(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 80'h0);
    serve(0, 0, 0);

    // Request raised and dropped while busy must not be granted
    set_req(0, 1'b0, 64'h5555_AAAA_5555_AAAA, 80'h3_3333_3333_3333_3333);
    fork
      serve(0, 0, 0);
      begin
        repeat (6) @(posedge clk);
        #1;
        set_req(1, 1'b0, 64'h7777, 80'h7777);
        repeat (3) @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
      end
    join
    check("dropped_no_ready", req_ready, 2'b00);
    step();
    check("dropped_no_start", core_start, 1'b0);

    // Stray core_done in IDLE is ignored
    inject_done = 1'b1;
    step();
    inject_done = 1'b0;
    bad = 0;
    repeat (3) begin
      step();
      if (rsp_valid != 2'b00) bad = 1;
    end
    check("stray_done_ignored", bad, 1'b0);
    check("stray_done_data", rsp_data, 64'h5555_AAAA_5555_AAAA ^ 64'h3333_3333_3333_3333);

    // Randomized traffic
    for (int it = 0; it < 10; it++) begin
      int pat;
      pat = $urandom_range(1, 3);
      for (int i = 0; i < 2; i++) begin
        if (pat[i]) set_req(i, 1'($urandom), {$urandom, $urandom}, {16'($urandom), $urandom, $urandom});
      end
      while (req_valid != 2'b00) serve($urandom_range(0, 4), bit'($urandom_range(0, 1)), 0);
    end

`ifdef BORON_ARB_TIMEOUT_EN
    suppress_done = 1'b1;
    set_req(0, 1'b0, 64'hABCD, 80'h1234);
    serve(0, 0, 1);
    suppress_done = 1'b0;
    set_req(1, 1'b1, 64'h0000_1111_2222_3333, 80'h9_8765_4321_0FED_CBA9);
    serve(0, 0, 0);
`else
    suppress_done = 1'b1;
    set_req(0, 1'b0, 64'hABCD, 80'h1234);
    step();
    req_valid = 2'b00;
    bad = 0;
    repeat (100) begin
      step();
      if (rsp_valid != 2'b00) bad = 1;
    end
    check("busy_waits_forever", bad, 1'b0);
    check("no_err_without_timeout", rsp_err, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    suppress_done = 1'b0;
    model_ptr = 1'b0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/boron_core_arbiter.md
# boron_core_arbiter

Shares one BORON cipher core (64-bit block, 80-bit key, 25 rounds, encrypt or decrypt) between two requesters. Each requester presents a block, key and mode through a valid/ready handshake. The arbiter grants one at a time in round-robin order, sequences the core with a start pulse, waits for done, and returns the result to the granted requester through a per-requester response handshake. It sits between the system-side crypto clients and the single enc/dec core instance.

## Interface
- TIMEOUT_CYCLES, 64: maximum BUSY cycles before abort; only used when the timeout feature is compiled in.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- req_valid  in  2  bit i: requester i has a request
- req_ready  out  2  bit i: request i accepted this cycle
- req_mode  in  2  bit i: 0 = encrypt, 1 = decrypt
- req_text  in  128  {text1, text0}, 64 bits each
- req_key  in  160  {key1, key0}, 80 bits each
- core_start  out  1  one-cycle start pulse to the core
- core_mode  out  1  mode of the latched request
- core_text  out  64  latched block
- core_key  out  80  latched key
- core_done  in  1  one-cycle pulse from the core; result valid in the same cycle
- core_result  in  64  core output
- rsp_valid  out  2  bit i: response for requester i pending
- rsp_ready  in  2  bit i: requester i takes the response
- rsp_data  out  64  result, shared by both requesters
- rsp_err  out  1  response is a timeout abort

## Operation
- FSM states: IDLE, ISSUE, BUSY, RESPOND. Reset state is IDLE.
- **IDLE**
  - If any req_valid bit is set, grant g = the round-robin choice.
  - req_ready[g]=1, combinationally, this cycle only.
  - Latch mode, text and key of requester g into the core_* registers. Go to ISSUE.
- **ISSUE**: core_start=1 for exactly one cycle. Go to BUSY.
- **BUSY**
  - On core_done, latch core_result into rsp_data, set rsp_err=0 and go to RESPOND.
  - core_done seen in any other state is ignored.
- **RESPOND**
  - rsp_valid[g]=1; hold it until rsp_ready[g]=1.
  - On the rsp_ready[g] cycle, set pointer = ~g and go to IDLE.
  - rsp_ready[~g] has no effect.
- **Round-robin**
  - 1-bit pointer, reset value 0.
  - Both requesters valid: grant the pointer side.
  - One requester valid: grant it regardless of pointer.
  - The pointer updates only on response completion.
- req_ready is 0 outside IDLE.
- Requesters must hold valid, mode, text and key stable until ready. Dropping valid before ready is permitted; no grant results.
- core_* registers stay stable from ISSUE until the next grant.
- Reset values: req_ready=0, core_start=0, core_mode=0, core_text=0, core_key=0, rsp_valid=0, rsp_data=0, rsp_err=0, pointer=0.
- Reset mid-operation: FSM returns to IDLE and the in-flight request is dropped with no response. The core is reset by the same reset.

## Timing
- Request accepted at cycle T (req_ready high).
- core_start at T+1.
- With core latency L (core_done at T+1+L), rsp_valid rises at T+2+L.
- Response handshake at cycle R; next grant possible at R+1.
- Minimum occupancy per operation is L+3 cycles with zero response backpressure.
- No request is queued while the core is busy; requesters wait with valid held.

## Configuration
- Macro: BORON_ARB_TIMEOUT_EN.
- **Defined**
  - An 8-bit-or-wider counter clears on entering BUSY and increments each BUSY cycle.
  - On reaching TIMEOUT_CYCLES without core_done: go to RESPOND with rsp_data=0 and rsp_err=1.
  - core_done in the same cycle as expiry wins: normal result, rsp_err=0.
- **Undefined**
  - BUSY waits indefinitely.
  - rsp_err is tied to 0 and no counter exists.

## Structure
- Shared package boron_pkg holds:
  - BLOCK_W=64, KEY_W=80, ROUNDS=25
  - mode encoding MODE_ENC=0, MODE_DEC=1
  - the FSM state typedef (2-bit)
- Sub-module boron_rr_arbiter: 2-way round-robin grant logic. Inputs are the request vector and pointer; outputs are the one-hot grant and grant index.

## Test plan
Stub core: fixed latency L=27; result = text ^ key[63:0] for encrypt, text ^ ~key[63:0] for decrypt.
- **Reset**: assert reset mid-BUSY -> all outputs 0, FSM in IDLE, no rsp_valid after release.
- **Single request**: req0 text=64'h0123456789ABCDEF, key=80'h0, encrypt at T -> core_start at T+1, rsp_valid[0] at T+29, rsp_data=64'h0123456789ABCDEF.
- **Contention**
  - Both valid from reset -> requester 0 served first, then requester 1.
  - Then both valid again -> requester 0 served next, since the pointer has alternated back to 0.
- **Backpressure**: rsp_ready[0] held low 10 cycles -> rsp_valid[0] and rsp_data stable, req_ready stays 0; stray rsp_ready[1] is ignored.
- **Decrypt mode**: req1 mode=1, text=64'hFFFFFFFFFFFFFFFF, key=80'h0 -> core_mode=1, rsp_data=64'h0.
- **Timeout (BORON_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64)**: core_done suppressed -> rsp_valid with rsp_err=1, rsp_data=0, 64 cycles after entering BUSY.
